// File: rtl/tpu_pkg.sv
// Shared fixed-point types and helpers for the TPU datapath (systolic array, VPU).
// Q8.8 signed arithmetic at the default widths.
package tpu_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef logic signed [15:0] fx16_t;

    // psum + ((a * w) >>> FRAC_W); the scaled product is clamped before the add
    // so a huge product cannot wrap inside the 17-bit sum.
    function automatic fx16_t sat_add_mul(input fx16_t psum, input fx16_t a, input fx16_t w);
        logic signed [31:0] a_x;
        logic signed [31:0] w_x;
        logic signed [31:0] prod;
        logic signed [31:0] term;
        logic signed [16:0] term_c;
        logic signed [16:0] sum;
        fx16_t              res;
        a_x  = {{16{a[15]}}, a};
        w_x  = {{16{w[15]}}, w};
        prod = a_x * w_x;
        term = prod >>> FRAC_W;
        if (term > 32'sh0000_7FFF) begin
            term_c = 17'sh0_7FFF;
        end else if (term < 32'shFFFF_8000) begin
            term_c = 17'sh1_8000;
        end else begin
            term_c = term[16:0];
        end
        sum = {psum[15], psum} + term_c;
        if (sum > 17'sh0_7FFF) begin
            res = 16'sh7FFF;
        end else if (sum < 17'sh1_8000) begin
            res = 16'sh8000;
        end else begin
            res = sum[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary processing element: double-buffered weight, saturating MAC,
// and a registered switch token that travels to the right/down neighbours.
module systolic_pe #(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int FRAC_W = tpu_pkg::FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_col_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic                     i_v,
    input  logic signed [DATA_W-1:0] i_psum,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic                     i_accept,
    input  logic                     i_switch,
    output logic signed [DATA_W-1:0] o_a,
    output logic                     o_v,
    output logic signed [DATA_W-1:0] o_psum,
    output logic signed [DATA_W-1:0] o_shadow,
    output logic                     o_switch
);

    localparam logic signed [2*DATA_W-1:0] L_WIDE_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] L_WIDE_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0]     L_SUM_MAX  = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0]     L_SUM_MIN  = {2'b11, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0]   L_ZERO     = {DATA_W{1'b0}};

    logic signed [DATA_W-1:0] r_a;
    logic                     r_v;
    logic signed [DATA_W-1:0] r_psum;
    logic signed [DATA_W-1:0] r_shadow;
    logic signed [DATA_W-1:0] r_active;
    logic                     r_switch;
    logic signed [DATA_W-1:0] w_mac;

    function automatic logic signed [DATA_W-1:0] mac_sat(
        input logic signed [DATA_W-1:0] psum,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] w
    );
        logic signed [2*DATA_W-1:0] a_x;
        logic signed [2*DATA_W-1:0] w_x;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [2*DATA_W-1:0] term;
        logic signed [DATA_W:0]     term_c;
        logic signed [DATA_W:0]     sum;
        logic signed [DATA_W-1:0]   res;
        a_x  = {{DATA_W{a[DATA_W-1]}}, a};
        w_x  = {{DATA_W{w[DATA_W-1]}}, w};
        prod = a_x * w_x;
        term = prod >>> FRAC_W;
        if (term > L_WIDE_MAX) begin
            term_c = L_SUM_MAX;
        end else if (term < L_WIDE_MIN) begin
            term_c = L_SUM_MIN;
        end else begin
            term_c = term[DATA_W:0];
        end
        sum = {psum[DATA_W-1], psum} + term_c;
        if (sum > L_SUM_MAX) begin
            res = L_SUM_MAX[DATA_W-1:0];
        end else if (sum < L_SUM_MIN) begin
            res = L_SUM_MIN[DATA_W-1:0];
        end else begin
            res = sum[DATA_W-1:0];
        end
        return res;
    endfunction

    // Multiply-accumulate against the currently active weight.
    always_comb begin
        w_mac = mac_sat(i_psum, i_a, r_active);
    end

    // Pipeline registers; a disabled column flushes psum/valid but still passes activations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= L_ZERO;
            r_v      <= 1'b0;
            r_psum   <= L_ZERO;
            r_shadow <= L_ZERO;
            r_active <= L_ZERO;
            r_switch <= 1'b0;
        end else begin
            r_a      <= i_a;
            r_switch <= i_switch;
            if (i_col_en) begin
                r_v    <= i_v;
                r_psum <= w_mac;
            end else begin
                r_v    <= 1'b0;
                r_psum <= L_ZERO;
            end
            if (i_accept) begin
                r_shadow <= i_w;
            end
            // Reads the pre-shift shadow when accept and switch coincide.
            if (i_switch) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_a      = r_a;
    assign o_v      = r_v;
    assign o_psum   = r_psum;
    assign o_shadow = r_shadow;
    assign o_switch = r_switch;

endmodule

// File: rtl/systolic_array_n.sv
// N x N weight-stationary systolic array: activations move right, partial sums move down,
// weight shadow chains shift down each column, and the switch token spreads diagonally.
module systolic_array_n #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 4,
    parameter int DATA_W               = tpu_pkg::DATA_W,
    parameter int FRAC_W               = tpu_pkg::FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sys_data_in   [0:SYSTOLIC_ARRAY_WIDTH-1],
    input  logic                     sys_valid_in  [0:SYSTOLIC_ARRAY_WIDTH-1],
    input  logic signed [DATA_W-1:0] sys_weight_in [0:SYSTOLIC_ARRAY_WIDTH-1],
    input  logic                     sys_accept_w  [0:SYSTOLIC_ARRAY_WIDTH-1],
    input  logic                     sys_switch_in,
    input  logic [15:0]              ub_rd_col_size_in,
    input  logic                     ub_rd_col_size_valid_in,
    output logic signed [DATA_W-1:0] sys_data_out  [0:SYSTOLIC_ARRAY_WIDTH-1],
    output logic                     sys_valid_out [0:SYSTOLIC_ARRAY_WIDTH-1]
);

    localparam int          N   = SYSTOLIC_ARRAY_WIDTH;
    localparam logic [15:0] L_N = 16'(SYSTOLIC_ARRAY_WIDTH);

    logic [15:0]              r_col_size;
    logic                     w_col_en [0:N-1];
    logic signed [DATA_W-1:0] w_a      [0:N-1][0:N-1];
    logic                     w_v      [0:N-1][0:N-1];
    logic signed [DATA_W-1:0] w_psum   [0:N-1][0:N-1];
    logic signed [DATA_W-1:0] w_shadow [0:N-1][0:N-1];
    logic                     w_sw     [0:N-1][0:N-1];

    // Enabled-column count, clamped to the physical width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_size <= L_N;
        end else if (ub_rd_col_size_valid_in) begin
            if (ub_rd_col_size_in > L_N) begin
                r_col_size <= L_N;
            end else begin
                r_col_size <= ub_rd_col_size_in;
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        assign w_col_en[j]      = (r_col_size > 16'(j));
        assign sys_data_out[j]  = w_psum[N-1][j];
        assign sys_valid_out[j] = w_v[N-1][j];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic signed [DATA_W-1:0] w_a_in;
            logic                     w_v_in;
            logic signed [DATA_W-1:0] w_psum_in;
            logic signed [DATA_W-1:0] w_w_in;
            logic                     w_sw_in;

            if (j == 0) begin : g_left
                assign w_a_in = sys_data_in[i];
                assign w_v_in = sys_valid_in[i];
            end else begin : g_inner_a
                assign w_a_in = w_a[i][j-1];
                assign w_v_in = w_v[i][j-1];
            end

            if (i == 0) begin : g_top
                assign w_psum_in = {DATA_W{1'b0}};
                assign w_w_in    = sys_weight_in[j];
            end else begin : g_inner_p
                assign w_psum_in = w_psum[i-1][j];
                assign w_w_in    = w_shadow[i-1][j];
            end

            // Token enters at PE(0,0); column 0 forwards it down, every other PE takes it from the left.
            if (i == 0 && j == 0) begin : g_sw_origin
                assign w_sw_in = sys_switch_in;
            end else if (j > 0) begin : g_sw_left
                assign w_sw_in = w_sw[i][j-1];
            end else begin : g_sw_up
                assign w_sw_in = w_sw[i-1][j];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .i_col_en (w_col_en[j]),
                .i_a      (w_a_in),
                .i_v      (w_v_in),
                .i_psum   (w_psum_in),
                .i_w      (w_w_in),
                .i_accept (sys_accept_w[j]),
                .i_switch (w_sw_in),
                .o_a      (w_a[i][j]),
                .o_v      (w_v[i][j]),
                .o_psum   (w_psum[i][j]),
                .o_shadow (w_shadow[i][j]),
                .o_switch (w_sw[i][j])
            );
        end
    end

endmodule

// File: tb/tb_systolic_array_n.sv
// Directed bench for systolic_array_n (N=4): reset, identity, column disable,
// double-buffered switch timing, saturation and mid-stream reset.
module tb_systolic_array_n;

    localparam int N = 4;
    localparam int M_ID = 0, M_DBUF = 1, M_SATP = 2, M_SATN = 3, M_HALF = 4, M_ZERO = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] data_in   [0:N-1];
    logic               valid_in  [0:N-1];
    logic signed [15:0] weight_in [0:N-1];
    logic               accept_w  [0:N-1];
    logic               switch_in;
    logic [15:0]        col_size;
    logic               col_size_valid;
    logic signed [15:0] data_out  [0:N-1];
    logic               valid_out [0:N-1];

    int n_vectors     = 0;
    int n_miscompares = 0;
    int g_mode        = M_ID;
    int g_cols        = N;
    int g_sw_s        = 0;

    always #5 clk = ~clk;

    systolic_array_n #(
        .SYSTOLIC_ARRAY_WIDTH (N),
        .DATA_W               (16),
        .FRAC_W               (8)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .sys_data_in             (data_in),
        .sys_valid_in            (valid_in),
        .sys_weight_in           (weight_in),
        .sys_accept_w            (accept_w),
        .sys_switch_in           (switch_in),
        .ub_rd_col_size_in       (col_size),
        .ub_rd_col_size_valid_in (col_size_valid),
        .sys_data_out            (data_out),
        .sys_valid_out           (valid_out)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] x_of(input int s, input int r);
        case (g_mode)
            M_SATP:  return 16'h7F00;
            M_SATN:  return 16'h8100;
            M_HALF:  return (r == 0) ? 16'h0080 : 16'h0000;
            default: return 16'(16'h0100 * (s + 1) + 16'h0010 * r);
        endcase
    endfunction

    function automatic logic [15:0] exp_of(input int s, input int j);
        if (j >= g_cols) return 16'h0000;
        case (g_mode)
            M_SATP:  return 16'h7FFF;
            M_SATN:  return 16'h8000;
            M_HALF:  return 16'h0040;
            M_ZERO:  return 16'h0000;
            M_DBUF:  return (s >= g_sw_s) ? 16'(2 * x_of(s, j)) : x_of(s, j);
            default: return x_of(s, j);
        endcase
    endfunction

    task automatic clear_inputs();
        for (int r = 0; r < N; r++) begin
            data_in[r]   = 16'sh0000;
            valid_in[r]  = 1'b0;
            weight_in[r] = 16'sh0000;
            accept_w[r]  = 1'b0;
        end
        switch_in      = 1'b0;
        col_size       = 16'h0000;
        col_size_valid = 1'b0;
    endtask

    // W[i][j] = diag on the diagonal, off elsewhere; bottom row is shifted in first.
    task automatic load_w(input logic [15:0] diag, input logic [15:0] off);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                weight_in[j] = ((N - 1 - k) == j) ? diag : off;
                accept_w[j]  = 1'b1;
            end
            tick();
        end
        for (int j = 0; j < N; j++) accept_w[j] = 1'b0;
        switch_in = 1'b1;
        tick();
        switch_in = 1'b0;
        repeat (2 * N) tick();
    endtask

    task automatic set_cols(input logic [15:0] v);
        col_size       = v;
        col_size_valid = 1'b1;
        tick();
        col_size_valid = 1'b0;
        tick();
    endtask

    // Skewed stream of ns samples; in M_DBUF a 2*I shadow load and a switch happen mid-stream.
    task automatic run_stream(input int ns);
        for (int c = 0; c < ns + 2 * N; c++) begin
            for (int r = 0; r < N; r++) begin
                if (c - r >= 0 && c - r < ns) begin
                    data_in[r]  = x_of(c - r, r);
                    valid_in[r] = 1'b1;
                end else begin
                    data_in[r]  = 16'sh0000;
                    valid_in[r] = 1'b0;
                end
            end
            if (g_mode == M_DBUF) begin
                for (int j = 0; j < N; j++) begin
                    weight_in[j] = (c < N && (N - 1 - c) == j) ? 16'h0200 : 16'h0000;
                    accept_w[j]  = (c < N);
                end
                switch_in = (c == 5);
            end
            tick();
            for (int j = 0; j < N; j++) begin
                int  s;
                logic ev;
                s  = c - (N - 1) - j;
                ev = (s >= 0 && s < ns && j < g_cols);
                check_val($sformatf("m%0d valid c%0d col%0d", g_mode, c, j), {15'h0000, valid_out[j]}, {15'h0000, ev});
                if (j >= g_cols || (s >= 0 && s < ns))
                    check_val($sformatf("m%0d data c%0d col%0d", g_mode, c, j), data_out[j], exp_of(s, j));
            end
        end
        for (int j = 0; j < N; j++) accept_w[j] = 1'b0;
        switch_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int j = 0; j < N; j++) begin
            check_val($sformatf("%s data col%0d", tag, j), data_out[j], 16'h0000);
            check_val($sformatf("%s valid col%0d", tag, j), {15'h0000, valid_out[j]}, 16'h0000);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < N; r++) begin
                data_in[r]   = 16'($urandom);
                valid_in[r]  = 1'($urandom);
                weight_in[r] = 16'($urandom);
                accept_w[r]  = 1'($urandom);
            end
            switch_in      = 1'($urandom);
            col_size       = 16'($urandom);
            col_size_valid = 1'($urandom);
            tick();
            check_all_zero("rst_hold");
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all_zero("post_rst");
        end

        load_w(16'h0100, 16'h0000);
        g_mode = M_ID;   g_cols = N; run_stream(8);
        set_cols(16'd2); g_cols = 2; run_stream(8);
        set_cols(16'd9); g_cols = N; run_stream(6);
        g_mode = M_DBUF; g_sw_s = 6; run_stream(12);

        load_w(16'h7F00, 16'h7F00);
        g_mode = M_SATP; run_stream(4);
        g_mode = M_SATN; run_stream(4);
        load_w(16'h0080, 16'h0080);
        g_mode = M_HALF; run_stream(4);

        load_w(16'h0100, 16'h0000);
        for (int r = 0; r < N; r++) begin
            data_in[r]  = 16'sh0300;
            valid_in[r] = 1'b1;
        end
        repeat (8) tick();
        check_val("pre_rst col0", data_out[0], 16'h0300);
        check_val("pre_rst col3", data_out[N-1], 16'h0300);
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        clear_inputs();
        tick();
        @(negedge clk);
        rst = 1'b1;
        g_mode = M_ZERO; g_cols = N; run_stream(4);
        load_w(16'h0100, 16'h0000);
        g_mode = M_ID; run_stream(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_array_n.md
Name: systolic_array_n

Overview:
- Parametrised N x N weight-stationary systolic array for 16-bit signed fixed point. Replaces the fixed 2x2 array between the unified buffer (left and top feeds) and the VPU (bottom outputs).
- Adds per-column double-buffered weights, a diagonally propagated switch, runtime column disable, and saturating accumulate.
- Activations flow left to right and partial sums flow top to bottom.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 4, array dimension N (rows = columns = N), range 1..16
- DATA_W, 16, operand and partial-sum width
- FRAC_W, 8, fractional bits (Q8.8 at defaults)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- sys_data_in[0:N-1]  in  DATA_W  activation into the left of row i; host/UB pre-skews row i by i cycles
- sys_valid_in[0:N-1]  in  1  activation valid per row
- sys_weight_in[0:N-1]  in  DATA_W  weight into the top of column j
- sys_accept_w[0:N-1]  in  1  shift-enable for the column j shadow chain
- sys_switch_in  in  1  pulse; copies shadow to active, propagating diagonally from PE(0,0)
- ub_rd_col_size_in  in  16  number of enabled columns
- ub_rd_col_size_valid_in  in  1  load strobe for ub_rd_col_size_in
- sys_data_out[0:N-1]  out  DATA_W  bottom-row partial sum, column j
- sys_valid_out[0:N-1]  out  1  output valid, column j

Behaviour:
- Reset (rst=0, asynchronous): all PE registers clear, including activation, valid, psum, shadow and active weight, and switch regs. Column-size register = N. sys_data_out = 0, sys_valid_out = 0. Any in-flight data is discarded.
- PE(i,j) per cycle:
  - a_out <= a_in; v_out <= v_in.
  - psum_out <= sat(psum_in + ((a_in * w_active) >>> FRAC_W)).
  - psum_in = 0 for row 0.
  - Product is 2*DATA_W signed, arithmetic right shift (floor). The sum is computed at DATA_W+1 bits and saturated to [0x8000, 0x7FFF].
- Valid: the bottom PE's valid register in column j drives sys_valid_out[j]. The valid of PE(i,j) follows its own row's left valid; no AND across rows.
- Latency: a row-0 sample at cycle t (rows pre-skewed, row i at t+i) yields column j output registered at t+N+j.
- Weight load: when sys_accept_w[j]=1, shadow(0,j) <= sys_weight_in[j] and shadow(i,j) <= shadow(i-1,j) for all i in the same edge. N accepts fill a column, bottom row value first. With accept=0 the shadow chain holds.
- Switch:
  - sys_switch_in is registered per PE and moves right and down, so PE(i,j) sees it at cycle t+i+j and copies shadow to active on that edge.
  - Switch and accept in the same cycle at one PE: active takes the pre-shift shadow value.
  - Back-to-back switch pulses are each honoured.
- Column disable:
  - Column-size register loads on ub_rd_col_size_valid_in; values > N clamp to N; 0 disables all columns.
  - For j >= col_size: every PE in column j forces psum_out = 0 and v_out = 0, so sys_data_out[j] = 0 and sys_valid_out[j] = 0.
  - A change takes effect on the next edge for all columns; in-flight data in a newly disabled column is zeroed.
- Activations still propagate through disabled columns, so enabled columns are unaffected.
- Invalid input (v_in=0): psum still computes, but output valid=0 and data is don't-care except in disabled columns (forced 0).

Decomposition:
- tpu_pkg holds: DATA_W, FRAC_W, typedef logic signed [15:0] fx16_t, and function sat_add_mul(psum, a, w) returning fx16_t. Shared with VPU modules.
- Sub-module systolic_pe: one PE with a/v/psum/shadow/active/switch registers, column-enable input, and ports for right and down neighbours.
- Top: generate loops over i and j; column-size register; edge tie-offs.

Test Plan:
- Reset: hold rst=0 with random inputs -> all sys_data_out=0, sys_valid_out=0. Release, with no stimulus -> outputs stay 0.
- Identity (N=4):
  - Stimulus: load W = I (diag 0x0100) over 4 accepts, pulse switch, wait 7 cycles, stream skewed X rows with X[r][c] = 0x0100*(r+1).
  - Response: column j output equals X column values; first valid at N+j cycles after row-0 start.
- Saturation:
  - All weights 0x7F00, inputs 0x7F00 -> outputs 0x7FFF.
  - Inputs 0x8100 (-127.0) with weights 0x7F00 -> 0x8000.
  - 0x0080 x 0x0080 -> 0x0040.
- Column disable: col_size=2 during identity stream -> columns 2,3 data 0 and valid 0, columns 0,1 correct. col_size=9 -> all 4 columns active.
- Double buffer:
  - During the identity stream, load 2*I (0x0200) into shadow -> outputs unchanged.
  - Pulse switch -> subsequent samples doubled, changing at PE(i,j) exactly i+j cycles after the pulse.
- Reset mid-stream: assert rst during streaming -> outputs 0 immediately (asynchronous), active weights 0. After release, reloading and re-switching reproduces the identity results.
